// File: rtl/stdcell_selftest_seq.sv
// Self-test sequencer: walks every input vector of the selected standard cell and
// checks the synchronised outputs against a built-in model. Option macro: STDCELL_SEQ_LOG_EN.
module stdcell_selftest_seq #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       start,
    input  logic [3:0] cell_sel,
    output logic [3:0] cut_in,
    input  logic [1:0] cut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count
`ifdef STDCELL_SEQ_LOG_EN
    ,
    output logic [3:0] fail_vec,
    output logic [1:0] fail_obs
`endif
);

    localparam int         SETTLE      = (SETTLE_CYCLES < 3) ? 3 : SETTLE_CYCLES;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [3:0] NUM_CELLS   = 4'd13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    // Last vector index (2^k - 1) for each cell.
    function automatic logic [3:0] last_vec(input logic [3:0] c);
        case (c)
            4'd0, 4'd1, 4'd7: return 4'd3;
            4'd2:             return 4'd7;
            4'd3:             return 4'd15;
            default:          return 4'd1;
        endcase
    endfunction

    // Expected {YC, Y/YS} for a cell driven with vector v.
    function automatic logic [1:0] cell_model(input logic [3:0] c, input logic [3:0] v);
        logic a, b, cc, d;
        a  = v[0];
        b  = v[1];
        cc = v[2];
        d  = v[3];
        case (c)
            4'd0, 4'd1:       return {1'b0, a & b};
            4'd2:             return {1'b0, ~((a & b) | cc)};
            4'd3:             return {1'b0, ~((a & b) | (cc & d))};
            4'd4, 4'd5, 4'd6: return {1'b0, a};
            4'd7:             return {a & b, a ^ b};
            default:          return {1'b0, ~a};
        endcase
    endfunction

    function automatic logic [1:0] cell_mask(input logic [3:0] c);
        return (c == 4'd7) ? 2'b11 : 2'b01;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] cell_q, cell_d;
    logic [3:0] vec_q, vec_d;
    logic [3:0] settle_cnt_q, settle_cnt_d;
    logic [3:0] cut_in_q, cut_in_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [4:0] err_count_q, err_count_d;
    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic       mismatch;
    logic [4:0] err_next;
`ifdef STDCELL_SEQ_LOG_EN
    logic [3:0] fail_vec_q, fail_vec_d;
    logic [1:0] fail_obs_q, fail_obs_d;
`endif

    always_comb begin
        state_d      = state_q;
        cell_d       = cell_q;
        vec_d        = vec_q;
        settle_cnt_d = settle_cnt_q;
        cut_in_d     = cut_in_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        err_count_d  = err_count_q;
        sync1_d      = cut_out;
        sync2_d      = sync1_q;
        mismatch     = |((sync2_q ^ cell_model(cell_q, vec_q)) & cell_mask(cell_q));
        err_next     = err_count_q + 5'(mismatch);
`ifdef STDCELL_SEQ_LOG_EN
        fail_vec_d   = fail_vec_q;
        fail_obs_d   = fail_obs_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cell_d      = cell_sel;
                    vec_d       = 4'd0;
                    err_count_d = 5'd0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
`ifdef STDCELL_SEQ_LOG_EN
                    fail_vec_d  = 4'd0;
                    fail_obs_d  = 2'd0;
`endif
                    state_d     = S_LAUNCH;
                end
            end
            // Launch cycle decides between running the vectors and rejecting the index.
            S_LAUNCH: begin
                if (cell_q >= NUM_CELLS) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    pass_d   = 1'b0;
                    cut_in_d = 4'd0;
                end else begin
                    state_d      = S_DRIVE;
                    cut_in_d     = vec_q;
                    settle_cnt_d = SETTLE_LOAD;
                end
            end
            S_DRIVE: begin
                if (settle_cnt_q == 4'd0) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_q - 4'd1;
                end
            end
            S_SAMPLE: begin
                err_count_d = err_next;
`ifdef STDCELL_SEQ_LOG_EN
                // Only the first failure of a run is logged.
                if (mismatch && (err_count_q == 5'd0)) begin
                    fail_vec_d = vec_q;
                    fail_obs_d = sync2_q;
                end
`endif
                if (vec_q == last_vec(cell_q)) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    pass_d   = (err_next == 5'd0);
                    cut_in_d = 4'd0;
                end else begin
                    vec_d        = vec_q + 4'd1;
                    cut_in_d     = vec_q + 4'd1;
                    settle_cnt_d = SETTLE_LOAD;
                    state_d      = S_DRIVE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                busy_d   = 1'b0;
                cut_in_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            cell_q       <= 4'd0;
            vec_q        <= 4'd0;
            settle_cnt_q <= 4'd0;
            cut_in_q     <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= 5'd0;
            sync1_q      <= 2'd0;
            sync2_q      <= 2'd0;
`ifdef STDCELL_SEQ_LOG_EN
            fail_vec_q   <= 4'd0;
            fail_obs_q   <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            cell_q       <= cell_d;
            vec_q        <= vec_d;
            settle_cnt_q <= settle_cnt_d;
            cut_in_q     <= cut_in_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_count_q  <= err_count_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
`ifdef STDCELL_SEQ_LOG_EN
            fail_vec_q   <= fail_vec_d;
            fail_obs_q   <= fail_obs_d;
`endif
        end
    end

    assign cut_in    = cut_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
`ifdef STDCELL_SEQ_LOG_EN
    assign fail_vec  = fail_vec_q;
    assign fail_obs  = fail_obs_q;
`endif

endmodule

// File: tb/tb_stdcell_selftest_seq.sv
// Directed bench for stdcell_selftest_seq: a behavioural CUT stand-in loops cut_in back
// onto cut_out, with selectable faults. Log checks follow STDCELL_SEQ_LOG_EN.
module tb_stdcell_selftest_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] cell_sel = 4'd0;
    logic [3:0] cut_in;
    logic [1:0] cut_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
`ifdef STDCELL_SEQ_LOG_EN
    logic [3:0] fail_vec;
    logic [1:0] fail_obs;
`endif

    int checks = 0;
    int errors = 0;
    int mode   = 0;
    int cyc    = 0;
    int seen_done = 0;

    stdcell_selftest_seq #(.SETTLE_CYCLES(4)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .start    (start),
        .cell_sel (cell_sel),
        .cut_in   (cut_in),
        .cut_out  (cut_out),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count)
`ifdef STDCELL_SEQ_LOG_EN
        ,
        .fail_vec (fail_vec),
        .fail_obs (fail_obs)
`endif
    );

    always #5 clk = ~clk;

    // CUT stand-in: 0 AND2, 1 stuck-at-0, 2 HAX1 with YC stuck 0, 3 AOI21, 4 AOI22.
    always_comb begin
        cut_out = 2'b00;
        case (mode)
            0: cut_out = {1'b0, cut_in[0] & cut_in[1]};
            1: cut_out = 2'b00;
            2: cut_out = {1'b0, cut_in[0] ^ cut_in[1]};
            3: cut_out = {1'b0, ~((cut_in[0] & cut_in[1]) | cut_in[2])};
            4: cut_out = {1'b0, ~((cut_in[0] & cut_in[1]) | (cut_in[2] & cut_in[3]))};
            default: cut_out = 2'b00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulses start so that it is sampled at edge 0; returns in cycle 0.
    task automatic launch(input logic [3:0] c);
        @(posedge clk); #1;
        start    = 1'b1;
        cell_sel = c;
        @(posedge clk); #1;
        start    = 1'b0;
        cyc      = 0;
    endtask

    // Advances to the cycle in which done is high, bounded.
    task automatic wait_done(input int max_cyc);
        while (cyc < max_cyc) begin
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) break;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_cut_in", 32'(cut_in), 32'd0);
`ifdef STDCELL_SEQ_LOG_EN
        chk("rst_fail_vec", 32'(fail_vec), 32'd0);
        chk("rst_fail_obs", 32'(fail_obs), 32'd0);
`endif
        rst = 1'b0;

        // AND2 loopback: cut_in steps 0..3 five cycles each, done in cycle 21.
        mode = 0;
        launch(4'd0);
        chk("and2_busy_c0", 32'(busy), 32'd1);
        chk("and2_cut_in_c0", 32'(cut_in), 32'd0);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            cyc = n;
            chk($sformatf("and2_cut_in_c%0d", n), 32'(cut_in), 32'((n - 1) / 5));
            chk($sformatf("and2_done_c%0d", n), 32'(done), 32'd0);
        end
        @(posedge clk); #1;
        chk("and2_done_c21", 32'(done), 32'd1);
        chk("and2_pass", 32'(pass), 32'd1);
        chk("and2_err", 32'(err_count), 32'd0);
        chk("and2_busy_c21", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("and2_busy_c22", 32'(busy), 32'd0);
        chk("and2_done_c22", 32'(done), 32'd0);
        chk("and2_pass_held", 32'(pass), 32'd1);

        // AOI22 with output stuck low: 9 of 16 vectors expect 1.
        mode = 1;
        launch(4'd3);
        chk("aoi22_pass_cleared", 32'(pass), 32'd0);
        wait_done(200);
        chk("aoi22_done_cycle", 32'(cyc), 32'd81);
        chk("aoi22_err", 32'(err_count), 32'd9);
        chk("aoi22_pass", 32'(pass), 32'd0);
`ifdef STDCELL_SEQ_LOG_EN
        chk("aoi22_fail_vec", 32'(fail_vec), 32'd0);
        chk("aoi22_fail_obs", 32'(fail_obs), 32'd0);
`endif

        // HAX1 with YC stuck low: only vector 3 mismatches.
        mode = 2;
        launch(4'd7);
        chk("hax_err_cleared", 32'(err_count), 32'd0);
        wait_done(100);
        chk("hax_done_cycle", 32'(cyc), 32'd21);
        chk("hax_err", 32'(err_count), 32'd1);
        chk("hax_pass", 32'(pass), 32'd0);
`ifdef STDCELL_SEQ_LOG_EN
        chk("hax_fail_vec", 32'(fail_vec), 32'd3);
        chk("hax_fail_obs", 32'(fail_obs), 32'd0);
`endif

        // Invalid index: immediate done with cut_in held at 0.
        mode = 0;
        launch(4'd14);
        chk("inv_cut_in_c0", 32'(cut_in), 32'd0);
        chk("inv_done_c0", 32'(done), 32'd0);
        @(posedge clk); #1;
        chk("inv_done_c1", 32'(done), 32'd1);
        chk("inv_pass", 32'(pass), 32'd0);
        chk("inv_err", 32'(err_count), 32'd0);
        chk("inv_cut_in_c1", 32'(cut_in), 32'd0);
        @(posedge clk); #1;
        chk("inv_busy_c2", 32'(busy), 32'd0);

        // AOI21 with start and cell_sel disturbed mid-run: no restart, 40 cycles.
        mode = 3;
        launch(4'd2);
        seen_done = 0;
        while (cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (cyc == 10) begin
                start    = 1'b1;
                cell_sel = 4'd0;
            end
            if (cyc == 40) chk("aoi21_cut_in_c40", 32'(cut_in), 32'd7);
            if (done === 1'b1) begin
                seen_done = cyc;
                break;
            end
        end
        start = 1'b0;
        chk("aoi21_done_cycle", 32'(seen_done), 32'd41);
        chk("aoi21_pass", 32'(pass), 32'd1);
        chk("aoi21_err", 32'(err_count), 32'd0);

        // AOI22 correct, reset pulsed during vector 2, then a clean rerun.
        mode = 4;
        launch(4'd3);
        while (cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rstmid_cut_in_c12", 32'(cut_in), 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_cut_in", 32'(cut_in), 32'd0);
        chk("rstmid_err", 32'(err_count), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        seen_done = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen_done++;
        end
        chk("rstmid_no_done", 32'(seen_done), 32'd0);
        chk("rstmid_idle_busy", 32'(busy), 32'd0);

        launch(4'd3);
        @(posedge clk); #1;
        cyc = 1;
        chk("rerun_cut_in_c1", 32'(cut_in), 32'd0);
        wait_done(200);
        chk("rerun_done_cycle", 32'(cyc), 32'd81);
        chk("rerun_pass", 32'(pass), 32'd1);
        chk("rerun_err", 32'(err_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stdcell_selftest_seq.md
# stdcell_selftest_seq

On-chip self-test sequencer for the standard-cell test array in the user project area. It selects one cell under test (CUT), drives every input combination onto the CUT inputs, waits a programmable settle time, and samples the CUT outputs through a synchroniser. Each sample is compared against a built-in behavioural model of that cell. Per-run pass/fail and a mismatch count are reported to the management side, so each cell's logic function can be checked without external pattern equipment.

## Interface

Parameters:

- `SETTLE_CYCLES`, default 4: cycles each vector is held before sampling; legal range 3–15, elaborated values below 3 are clamped to 3.

Ports:

- `wb_clk_i` in 1: single clock for the whole block.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle run request; only accepted in IDLE.
- `cell_sel` in 4: CUT index, latched on an accepted `start`.
- `cut_in` out 4: vector driven to the CUT pins; A=bit0, B=bit1, C=bit2, D=bit3.
- `cut_out` in 2: CUT outputs; bit0 is Y or YS, bit1 is YC (HAX1 only).
- `busy` out 1: high from the cycle after an accepted `start` until DONE is left.
- `done` out 1: one-cycle pulse at end of run.
- `pass` out 1: run result, held until the next accepted `start`.
- `err_count` out 5: number of mismatching vectors, held like `pass`.
- `fail_vec` out 4: first failing vector; present only with the log option.
- `fail_obs` out 2: synchronised outputs at the first failure; present only with the log option.

## Operation

- Cell map, as index: cell (number of inputs k, expected function):
  - 0 AND2X1 and 1 AND2X2 (k=2): Y = A&B.
  - 2 AOI21X1 (k=3): Y = ~((A&B)|C).
  - 3 AOI22X1 (k=4): Y = ~((A&B)|(C&D)).
  - 4 BUFX2, 5 BUFX4, 6 CLKBUF1 (k=1): Y = A.
  - 7 HAX1 (k=2): YS = A^B, YC = A&B.
  - 8 INV, 9 INVX1, 10 INVX2, 11 INVX4, 12 INVX8 (k=1): Y = ~A.
- Only bit0 of `cut_out` is compared, except for HAX1, which compares both bits.
- `cut_out` passes through a 2-flop synchroniser before comparison.
- State machine:
  - IDLE: waits for `start`. On `start`, latch `cell_sel`, clear `vec`, `err_count` and `pass`, then go to DRIVE. If `cell_sel` ≥ 13, go directly to DONE with `pass`=0 and `err_count`=0.
  - DRIVE: `cut_in` = `vec` zero-extended; input bits at or above k are driven 0. Load `settle_cnt` on entry. Stay SETTLE_CYCLES cycles, then go to SAMPLE.
  - SAMPLE: one cycle. Compare the synchroniser output with the model of `vec`; on mismatch increment `err_count`. If `vec` = 2^k−1, go to DONE; otherwise increment `vec` and go to DRIVE.
  - DONE: one cycle. `done`=1, and `pass` = (`err_count`==0 and `cell_sel` valid). Return to IDLE.
- Outside DRIVE and SAMPLE, `cut_in` is driven 0.
- `start` while `busy` is ignored.
- `cell_sel` changes after it is latched have no effect on the run in progress.

## Timing

- Reset values: `cut_in`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0, `fail_obs`=0, state = IDLE, synchroniser flops = 0.
- `start` is sampled at edge 0. DRIVE starts at edge 1, and `cut_in` carries the new vector from edge 1.
- Each vector takes SETTLE_CYCLES+1 cycles.
- Run length for a valid cell: 2^k·(SETTLE_CYCLES+1) cycles from the first DRIVE edge, then 1 DONE cycle.
  - Example, AND2 with default 4: DRIVE starts at edge 1, `done` is high in cycle 21, and `busy` falls after it.
- Invalid cell: `done` is high in cycle 1 after `start`.
- Sampling happens at least 3 cycles after a `cut_in` change, which covers 2 synchroniser stages plus pad/cell delay.
- Reset asserted at any edge, including mid-run, returns all outputs and state to reset values at that edge; no `done` pulse is produced.
- `start` coincident with `wb_rst_i` is ignored.

## Configuration

- `STDCELL_SEQ_LOG_EN` defined:
  - Adds `fail_vec` and `fail_obs` registers.
  - On the first mismatch of a run, they capture `vec` and the synchronised `cut_out`.
  - Both are cleared on an accepted `start` and held after DONE.
- `STDCELL_SEQ_LOG_EN` undefined: both ports are omitted and no capture logic is built. All other behaviour is identical.

## Test plan

- Loopback model, cell 0, SETTLE_CYCLES=4: bench drives `cut_out[0]` = A&B. Required: `done` in cycle 21, `pass`=1, `err_count`=0, and `cut_in` stepping 0,1,2,3 with each value held 5 cycles.
- Cell 3, bench ties `cut_out[0]`=0: 16 vectors, of which 9 expect 1. Required: `err_count`=9, `pass`=0. With the log option, `fail_vec`=0 and `fail_obs`=0.
- Cell 7 with YC stuck at 0: 4 vectors, mismatch only at vec 3. Required: `err_count`=1, `pass`=0. With the log option, `fail_vec`=3 and `fail_obs`=2'b00.
- `cell_sel`=14: required `done` in cycle 1 after `start`, `pass`=0, `err_count`=0, and `cut_in` stays 0.
- `start` pulsed and `cell_sel` changed mid-run on cell 2: required no restart, run completes on cell 2 in 8·5 cycles.
- `wb_rst_i` for 1 cycle during vec 2 of cell 3: required `busy`, `cut_in` and `err_count` = 0 at the next edge and no `done` pulse. A new `start` then runs cleanly from vec 0.
